counter_bcd_scanner: RTL and testbench
======================================

# counter_bcd_scanner

Sequential binary-to-BCD conversion stage between the 16-entry counter bank (packed 256-bit `data_raw` bus) and the VGA text generator. It sweeps the 16 unsigned 16-bit counters one at a time. Each one goes through an iterative double-dabble shifter, and the result is stored as 5 BCD digits in a 320-bit display buffer. The text generator reads decimal digits directly from that buffer, with no per-pixel arithmetic.

## Interface
Parameters:
- `N_ENTRIES`, 16, number of counters swept.
- `BIN_W`, 16, width of each binary counter.
- `DIGITS`, 5, BCD digits per entry. 5 digits cover 0..65535.

Ports:
- `clk`, in, 1: system clock (100 MHz).
- `reset`, in, 1: asynchronous, active-high reset.
- `enable`, in, 1: run sweeps continuously while high.
- `data_raw`, in, 256: packed counters. Entry k occupies bits [255-16k -: 16], so entry 0 is in the MSBs.
- `bcd_flat`, out, 320: display buffer. Entry k occupies bits [319-20k -: 20]. Within an entry, bits [19:16] are the ten-thousands digit and bits [3:0] are the units digit.
- `busy`, out, 1: high whenever the state is not IDLE.
- `sweep_done`, out, 1: one-cycle pulse after entry 15 is stored.

## Operation
- FSM states: IDLE, LOAD, SHIFT, STORE. Internal registers:
  - `idx` (4 bits), entry pointer.
  - `cnt` (4 bits), shift counter.
  - `sr` (36 bits): BCD section [35:16] and binary section [15:0].
- IDLE:
  - `enable`=1 → LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - `sr` ← {20'b0, entry[idx] of `data_raw`}, `cnt` ← 0, then → SHIFT.
  - This is the only point at which `data_raw` is sampled. Later changes to the input do not affect the conversion in progress.
- SHIFT (exactly 16 cycles), each cycle:
  - Each of the 5 BCD nibbles in `sr` that is ≥5 gets +3.
  - The corrected 36-bit value is then shifted left by 1, with a 0 shifted in.
  - `cnt`++.
  - When `cnt`=15, → STORE.
- STORE:
  - Buffer entry[idx] ← `sr`[35:16].
  - If `idx`=15: `idx` ← 0, pulse `sweep_done`, → IDLE.
  - Otherwise: `idx`++, → LOAD.
- `enable` is sampled only in IDLE. Dropping it mid-sweep does not stop the sweep: the current sweep completes, then the FSM stays in IDLE.
- Buffer entries update individually, so each entry is always a complete, valid conversion. Entries within one sweep may come from different source snapshots.
- All arithmetic is unsigned. No digit can exceed 9 after a conversion, and the maximum output is 6_5_5_3_5.
- Reset, asynchronous, immediate, at any point including mid-conversion:
  - State ← IDLE.
  - `idx`, `cnt`, `sr` ← 0.
  - Every buffer entry ← 0.
  - `busy`=0, `sweep_done`=0.

## Timing
- Reset values: `bcd_flat`=0, `busy`=0, `sweep_done`=0.
- Let E0 be the first rising edge in IDLE with `enable`=1. Edges are numbered from E0.
- Per entry k:
  - LOAD at edge E1+18k; `data_raw` is sampled at that edge.
  - Shifts occur at edges E2+18k .. E17+18k.
  - The buffer write occurs at edge E18+18k and is visible on `bcd_flat` in the following cycle.
- Entry 15 is written at E288. `sweep_done` is high for the single cycle after E288.
- The next sweep's LOAD is at E290 if `enable` is still high, giving a sweep period of 289 cycles.
- `busy` is a registered state decode: high from E0 through E288, low in the cycle after E288.
- Conversion latency per entry is 18 cycles from LOAD to visible output.

## Test plan
- Reset, then hold `enable`=0 for 100 cycles → `bcd_flat`=0, `busy`=0, `sweep_done` never pulses.
- `data_raw` = {16'd0,16'd1,...,16'd15} with `enable`=1 → after the first `sweep_done`, entry k is BCD of k (entry 15 = 0_0_0_1_5). `sweep_done` pulses exactly 289 cycles after E0 and every 289 cycles thereafter.
- Set entry 0 = 65535, entry 7 = 12345, entry 15 = 9 → entry 0 = 6_5_5_3_5, entry 7 = 1_2_3_4_5, entry 15 = 0_0_0_0_9. Entry 0 is visible at E18+1.
- Change entry 3 from 100 to 999 during entry 3's SHIFT phase → entry 3 = 0_0_1_0_0 this sweep and 0_0_9_9_9 after the next sweep.
- Drop `enable` at E50 → the sweep completes and `sweep_done` pulses once after E288. `busy` stays 0 afterwards and the buffer holds.
- Assert `reset` at E100, mid-entry-5, for 1 cycle → `bcd_flat`=0 and `busy`=0 immediately. With `enable` high, restart begins at entry 0.

Source files
------------

// File: rtl/counter_bcd_scanner.sv
// -----------------------------------------------------------------------------
// counter_bcd_scanner
//
// Purpose:
//   Converts a bank of unsigned binary counters into decimal digits for the
//   VGA text generator. Entries are processed one at a time. Each entry is
//   captured from the packed input bus, run through an iterative double-dabble
//   shifter, and its BCD digits are written into a display buffer. The text
//   generator can then read decimal digits directly, with no per-pixel
//   arithmetic.
//
// Ports:
//   clk         in   1                    system clock
//   reset       in   1                    asynchronous, active-high reset
//   enable      in   1                    start a new sweep whenever idle
//   data_raw    in   N_ENTRIES*BIN_W      packed counters, entry 0 in the MSBs
//   bcd_flat    out  N_ENTRIES*DIGITS*4   display buffer, entry 0 in the MSBs,
//                                         units digit in the low nibble
//   busy        out  1                    registered "not idle" flag
//   sweep_done  out  1                    one-cycle pulse after the last entry
//                                         has been stored
// -----------------------------------------------------------------------------
module counter_bcd_scanner #(
    parameter int N_ENTRIES = 16,
    parameter int BIN_W     = 16,
    parameter int DIGITS    = 5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [N_ENTRIES*BIN_W-1:0]      data_raw,
    output logic [N_ENTRIES*DIGITS*4-1:0]   bcd_flat,
    output logic                            busy,
    output logic                            sweep_done
);

    localparam int BCD_W = DIGITS * 4;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ENTRIES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_STORE = 2'd3;

    // One double-dabble iteration. Every BCD nibble of 5 or more gets +3 so
    // that the following doubling carries correctly into the next decade.
    // The binary section is left untouched by the correction.
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr_in);
        logic [SR_W-1:0] corrected;
        corrected = sr_in;
        for (int d = 0; d < DIGITS; d++) begin
            if (corrected[BIN_W + 4*d +: 4] >= 4'd5) begin
                corrected[BIN_W + 4*d +: 4] = corrected[BIN_W + 4*d +: 4] + 4'd3;
            end else begin
                corrected[BIN_W + 4*d +: 4] = corrected[BIN_W + 4*d +: 4];
            end
        end
        return {corrected[SR_W-2:0], 1'b0};
    endfunction

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [SR_W-1:0]  r_sr;
    logic [BCD_W-1:0] r_buf [N_ENTRIES];
    logic             r_busy;
    logic             r_sweep_done;

    // Unpacked view of the input bus, entry 0 sitting in the MSBs.
    logic [BIN_W-1:0] w_entries [N_ENTRIES];

    genvar g;
    generate
        for (g = 0; g < N_ENTRIES; g++) begin : g_unpack
            assign w_entries[g] = data_raw[(N_ENTRIES-1-g)*BIN_W +: BIN_W];
            assign bcd_flat[(N_ENTRIES-1-g)*BCD_W +: BCD_W] = r_buf[g];
        end
    endgenerate

    assign busy       = r_busy;
    assign sweep_done = r_sweep_done;

    // Next-state decode for the sweep FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                // enable is only looked at here; a running sweep always completes
                if (enable) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_STORE;
                end else begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_STORE: begin
                if (r_idx == IDX_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, datapath, display buffer and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_sr         <= '0;
            r_busy       <= 1'b0;
            r_sweep_done <= 1'b0;
            for (int k = 0; k < N_ENTRIES; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            r_state      <= w_state_nxt;
            // busy follows the state being entered, so it is a clean flop output
            r_busy       <= (w_state_nxt != S_IDLE);
            r_sweep_done <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    // Sole sampling point of data_raw for this entry
                    r_sr  <= {{BCD_W{1'b0}}, w_entries[r_idx]};
                    r_cnt <= '0;
                end
                S_SHIFT: begin
                    r_sr  <= dabble_step(r_sr);
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_STORE: begin
                    // Whole-entry write keeps every buffer entry a complete conversion
                    r_buf[r_idx] <= r_sr[SR_W-1 -: BCD_W];
                    if (r_idx == IDX_LAST) begin
                        r_idx        <= '0;
                        r_sweep_done <= 1'b1;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                    r_sr <= r_sr;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_bcd_scanner.sv
// -----------------------------------------------------------------------------
// tb_counter_bcd_scanner
//
// Self-checking bench for counter_bcd_scanner. The reference model counts
// edges from the start of each sweep, snapshots each entry at its load edge,
// and predicts the display buffer as plain decimal values converted with
// division and modulo.
// -----------------------------------------------------------------------------
module tb_counter_bcd_scanner;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [255:0] data_raw;
    logic [319:0] bcd_flat;
    logic         busy;
    logic         sweep_done;

    always #5 clk = ~clk;

    counter_bcd_scanner #(
        .N_ENTRIES (16),
        .BIN_W     (16),
        .DIGITS    (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .data_raw   (data_raw),
        .bcd_flat   (bcd_flat),
        .busy       (busy),
        .sweep_done (sweep_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int unsigned exp_val [16];
    int unsigned snap    [16];
    bit          m_active;
    int          m_e;
    bit          exp_done;

    task automatic check_val(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int unsigned v);
        return {4'(v / 10000 % 10), 4'(v / 1000 % 10), 4'(v / 100 % 10),
                4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [319:0] exp_flat();
        logic [319:0] f;
        f = '0;
        for (int k = 0; k < 16; k++) begin
            f[319-20*k -: 20] = to_bcd(exp_val[k]);
        end
        return f;
    endfunction

    function automatic int unsigned entry_of(input logic [255:0] d, input int k);
        return int'(d[255-16*k -: 16]);
    endfunction

    function automatic logic [19:0] dut_entry(input int k);
        return bcd_flat[319-20*k -: 20];
    endfunction

    task automatic set_entry(input int k, input int unsigned v);
        logic [31:0] vv;
        vv = v;
        data_raw[255-16*k -: 16] = vv[15:0];
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_e      = 0;
        exp_done = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp_val[k] = 0;
            snap[k]    = 0;
        end
    endtask

    function automatic int unsigned rand_val();
        case ($urandom_range(0, 3))
            0:       return 65535;
            1:       return $urandom_range(0, 9);
            default: return $urandom_range(0, 65535);
        endcase
    endfunction

    // One clock: inputs as they stand at the edge feed the model, outputs are
    // compared 1 time unit after the edge.
    task automatic cycle();
        bit           en;
        bit           rs;
        logic [255:0] d;
        en = enable;
        rs = reset;
        d  = data_raw;
        @(posedge clk);
        exp_done = 1'b0;
        if (rs) begin
            model_reset();
        end else if (!m_active) begin
            if (en) begin
                m_active = 1'b1;
                m_e      = 0;
            end
        end else begin
            m_e++;
            if (m_e >= 1 && (m_e - 1) % 18 == 0) begin
                snap[(m_e - 1) / 18] = entry_of(d, (m_e - 1) / 18);
            end
            if (m_e >= 18 && m_e % 18 == 0) begin
                exp_val[m_e / 18 - 1] = snap[m_e / 18 - 1];
            end
            if (m_e == 288) begin
                m_active = 1'b0;
                exp_done = 1'b1;
            end
        end
        #1;
        check_val("busy", busy, m_active);
        check_val("sweep_done", sweep_done, exp_done);
        check_val("bcd_flat", bcd_flat, exp_flat());
    endtask

    task automatic run_cycles(input int n, input bit churn);
        for (int i = 0; i < n; i++) begin
            cycle();
            if (churn && $urandom_range(0, 3) == 0) begin
                set_entry($urandom_range(0, 15), rand_val());
            end
        end
    endtask

    task automatic run_until_done(input int limit);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!exp_done && n < limit);
        check_val("sweep_reached", sweep_done, 1'b1);
    endtask

    task automatic run_until_edge(input int target, input int limit);
        int n;
        n = 0;
        while (!(m_active && m_e == target) && n < limit) begin
            cycle();
            n++;
        end
        check_val("edge_reached", m_e, target);
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        model_reset();
        #1;
        check_val("rst_bcd_now", bcd_flat, '0);
        check_val("rst_busy_now", busy, 1'b0);
        check_val("rst_done_now", sweep_done, 1'b0);
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        data_raw = '0;
        model_reset();
        #3;
        check_val("reset_bcd", bcd_flat, '0);
        check_val("reset_busy", busy, 1'b0);
        check_val("reset_done", sweep_done, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle with enable low and a noisy input bus
        for (int i = 0; i < 100; i++) begin
            data_raw = {$urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom};
            cycle();
        end

        // Ramp pattern, continuous sweeps
        for (int k = 0; k < 16; k++) begin
            set_entry(k, k);
        end
        enable = 1'b1;
        run_until_done(400);
        check_val("ramp_e0", dut_entry(0), 20'h00000);
        check_val("ramp_e9", dut_entry(9), 20'h00009);
        check_val("ramp_e15", dut_entry(15), 20'h00015);
        run_until_done(400);

        // Boundary values
        for (int k = 0; k < 16; k++) begin
            set_entry(k, rand_val());
        end
        set_entry(0, 65535);
        set_entry(7, 12345);
        set_entry(15, 9);
        run_until_done(400);
        run_until_done(400);
        check_val("max_e0", dut_entry(0), 20'h65535);
        check_val("mid_e7", dut_entry(7), 20'h12345);
        check_val("nine_e15", dut_entry(15), 20'h00009);

        // Input change while entry 3 is shifting
        set_entry(3, 100);
        run_until_edge(60, 400);
        set_entry(3, 999);
        run_until_done(400);
        check_val("snap_e3_old", dut_entry(3), 20'h00100);
        run_until_done(400);
        check_val("snap_e3_new", dut_entry(3), 20'h00999);

        // Random churn over a couple of sweeps
        run_cycles(600, 1'b1);

        // Enable dropped mid-sweep
        run_until_done(400);
        run_until_edge(49, 400);
        enable = 1'b0;
        run_until_done(400);
        run_cycles(300, 1'b1);

        // Reset mid-entry-5 with enable high
        enable = 1'b1;
        run_until_edge(100, 400);
        reset_pulse();
        run_until_done(400);
        run_cycles(50, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
